// File: rtl/mpt_pkg.sv
// Shared MPT types: modes, access kinds, permission encodings, PLB entry
// layout and the permission-check helper used by the lookaside buffer.
`timescale 1ns/1ps
package mpt_pkg;

  localparam int PLEN        = 56;
  localparam int SDID_LEN    = 6;
  localparam int PAGE_OFFSET = 12;

  typedef enum logic [1:0] {
    MPT_BARE    = 2'd0,
    MPT_SMMPT43 = 2'd1,
    MPT_SMMPT52 = 2'd2,
    MPT_SMMPT64 = 2'd3
  } mpt_mode_e;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } mpt_access_e;

  typedef enum logic [2:0] {
    DISALLOWED = 3'd0,
    ALLOW_R    = 3'd1,
    ALLOW_RW   = 3'd3,
    ALLOW_RX   = 3'd5,
    ALLOW_RWX  = 3'd7
  } mpt_permissions_e;

  typedef struct packed {
    logic [SDID_LEN-1:0]         sdid;
    logic [PLEN-PAGE_OFFSET-1:0] tag;
    mpt_permissions_e            perm;
  } plb_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WALK_REQ  = 2'd1,
    WALK_WAIT = 2'd2
  } plb_state_e;

  function automatic logic mpt_perm_allows(input mpt_permissions_e perm,
                                           input mpt_access_e      access);
    logic ok;
    unique case (access)
      ACCESS_WRITE: ok = (perm == ALLOW_RW) || (perm == ALLOW_RWX);
      ACCESS_EXEC:  ok = (perm == ALLOW_RX) || (perm == ALLOW_RWX);
      default:      ok = (perm != DISALLOWED);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mpt_plb_victim_sel.sv
// Fill victim choice for the PLB: lowest-index invalid entry, otherwise a
// round-robin pointer that only moves on fills into a full buffer.
`timescale 1ns/1ps
module mpt_plb_victim_sel #(
  parameter  int NUM_ENTRIES = 8,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  logic                   fill_i,
  output logic [IDX_W-1:0]       victim_o
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] first_inv;
  logic             any_inv;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    first_inv = '0;
    any_inv   = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        first_inv = IDX_W'(i);
        any_inv   = 1'b1;
      end
    end
    victim_o = any_inv ? first_inv : rr_q;
    rr_d     = rr_q;
    if (fill_i && !any_inv) begin
      rr_d = (rr_q == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/mpt_plb.sv
// Permission Lookaside Buffer: fully associative per-page permission cache in
// front of the MPT walker, tagged by SDID, with selective or global flush.
`timescale 1ns/1ps
module mpt_plb
  import mpt_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int PLEN        = mpt_pkg::PLEN,
  parameter int SDID_LEN    = mpt_pkg::SDID_LEN
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  mpt_mode_e           mode_i,
  input  logic                lookup_valid_i,
  output logic                lookup_ready_o,
  input  logic [PLEN-1:0]     lookup_spa_i,
  input  logic [SDID_LEN-1:0] lookup_sdid_i,
  input  mpt_access_e         lookup_access_i,
  output logic                resp_valid_o,
  output logic                resp_allow_o,
  output logic                resp_fault_o,
  output mpt_permissions_e    resp_perm_o,
  output logic                ptw_req_valid_o,
  input  logic                ptw_req_ready_i,
  output logic [PLEN-1:0]     ptw_req_spa_o,
  output logic [SDID_LEN-1:0] ptw_req_sdid_o,
  input  logic                ptw_resp_valid_i,
  input  logic                ptw_resp_error_i,
  input  mpt_permissions_e    ptw_resp_perm_i,
  input  logic                flush_i,
  input  logic                flush_sdid_valid_i,
  input  logic [SDID_LEN-1:0] flush_sdid_i
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  plb_state_e             state_q;
  logic                   ready_q;
  logic                   resp_valid_q, resp_allow_q, resp_fault_q;
  mpt_permissions_e       resp_perm_q;
  logic                   ptw_req_valid_q;
  logic [PLEN-1:0]        req_spa_q;
  logic [SDID_LEN-1:0]    req_sdid_q;
  mpt_access_e            req_access_q;
  logic                   drop_q;
  logic [NUM_ENTRIES-1:0] valid_q;
  plb_entry_t             entries_q [NUM_ENTRIES];

  logic                   accept, hit, fill_en;
  mpt_permissions_e       hit_perm;
  logic [NUM_ENTRIES-1:0] flush_hit;
  logic [IDX_W-1:0]       victim;

  assign accept  = lookup_valid_i && ready_q;
  assign fill_en = (state_q == WALK_WAIT) && ptw_resp_valid_i && !ptw_resp_error_i
                   && !drop_q && !flush_i;

  always_comb begin
    hit       = 1'b0;
    hit_perm  = DISALLOWED;
    flush_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && entries_q[i].sdid == lookup_sdid_i &&
          entries_q[i].tag == lookup_spa_i[PLEN-1:PAGE_OFFSET]) begin
        hit      = 1'b1;
        hit_perm = entries_q[i].perm;
      end
      flush_hit[i] = flush_i && (!flush_sdid_valid_i || entries_q[i].sdid == flush_sdid_i);
    end
  end

  mpt_plb_victim_sel #(.NUM_ENTRIES(NUM_ENTRIES)) u_victim_sel (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_q),
    .fill_i   (fill_en),
    .victim_o (victim)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (flush_hit[i]) valid_q[i] <= 1'b0;
      end
      if (fill_en) valid_q[victim] <= 1'b1;
    end
  end

  // NOTE: entry payload is left unreset; the separately reset valid bits make stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      entries_q[victim] <= '{sdid: req_sdid_q,
                             tag:  req_spa_q[PLEN-1:PAGE_OFFSET],
                             perm: ptw_resp_perm_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      ready_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_allow_q    <= 1'b0;
      resp_fault_q    <= 1'b0;
      resp_perm_q     <= DISALLOWED;
      ptw_req_valid_q <= 1'b0;
      req_spa_q       <= '0;
      req_sdid_q      <= '0;
      req_access_q    <= ACCESS_NONE;
      drop_q          <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (mode_i == MPT_BARE) begin
              resp_valid_q <= 1'b1;
              resp_allow_q <= 1'b1;
              resp_fault_q <= 1'b0;
              resp_perm_q  <= ALLOW_RWX;
            end else if (hit) begin
              resp_valid_q <= 1'b1;
              resp_allow_q <= mpt_perm_allows(hit_perm, lookup_access_i);
              resp_fault_q <= 1'b0;
              resp_perm_q  <= hit_perm;
            end else begin
              state_q         <= WALK_REQ;
              ready_q         <= 1'b0;
              ptw_req_valid_q <= 1'b1;
              req_spa_q       <= lookup_spa_i;
              req_sdid_q      <= lookup_sdid_i;
              req_access_q    <= lookup_access_i;
              // A flush racing the miss may invalidate what the walk returns.
              drop_q          <= flush_i;
            end
          end
        end
        WALK_REQ: begin
          if (flush_i) drop_q <= 1'b1;
          if (ptw_req_ready_i) begin
            ptw_req_valid_q <= 1'b0;
            state_q         <= WALK_WAIT;
          end
        end
        WALK_WAIT: begin
          if (flush_i) drop_q <= 1'b1;
          if (ptw_resp_valid_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            if (ptw_resp_error_i) begin
              resp_allow_q <= 1'b0;
              resp_fault_q <= 1'b1;
              resp_perm_q  <= DISALLOWED;
            end else begin
              resp_allow_q <= mpt_perm_allows(ptw_resp_perm_i, req_access_q);
              resp_fault_q <= 1'b0;
              resp_perm_q  <= ptw_resp_perm_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lookup_ready_o  = ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_allow_o    = resp_allow_q;
  assign resp_fault_o    = resp_fault_q;
  assign resp_perm_o     = resp_perm_q;
  assign ptw_req_valid_o = ptw_req_valid_q;
  assign ptw_req_spa_o   = req_spa_q;
  assign ptw_req_sdid_o  = req_sdid_q;

endmodule

// File: tb/tb_mpt_plb.sv
// Bench for mpt_plb: directed scenarios plus randomized lookups, walks and
// flushes compared against a behavioural cache model kept in this module.
`timescale 1ns/1ps
module tb_mpt_plb;
  import mpt_pkg::*;

  localparam int NE    = 8;
  localparam int TAG_W = PLEN - PAGE_OFFSET;

  logic                clk = 1'b0;
  logic                rst_i;
  mpt_mode_e           mode_i;
  logic                lookup_valid_i;
  logic                lookup_ready_o;
  logic [PLEN-1:0]     lookup_spa_i;
  logic [SDID_LEN-1:0] lookup_sdid_i;
  mpt_access_e         lookup_access_i;
  logic                resp_valid_o, resp_allow_o, resp_fault_o;
  mpt_permissions_e    resp_perm_o;
  logic                ptw_req_valid_o, ptw_req_ready_i;
  logic [PLEN-1:0]     ptw_req_spa_o;
  logic [SDID_LEN-1:0] ptw_req_sdid_o;
  logic                ptw_resp_valid_i, ptw_resp_error_i;
  mpt_permissions_e    ptw_resp_perm_i;
  logic                flush_i, flush_sdid_valid_i;
  logic [SDID_LEN-1:0] flush_sdid_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mpt_plb #(.NUM_ENTRIES(NE)) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_spa_i(lookup_spa_i), .lookup_sdid_i(lookup_sdid_i),
    .lookup_access_i(lookup_access_i),
    .resp_valid_o(resp_valid_o), .resp_allow_o(resp_allow_o),
    .resp_fault_o(resp_fault_o), .resp_perm_o(resp_perm_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_req_spa_o(ptw_req_spa_o), .ptw_req_sdid_o(ptw_req_sdid_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_error_i(ptw_resp_error_i),
    .ptw_resp_perm_i(ptw_resp_perm_i),
    .flush_i(flush_i), .flush_sdid_valid_i(flush_sdid_valid_i),
    .flush_sdid_i(flush_sdid_i)
  );

  // Reference cache: what a page's permission is, per domain, after fills/evictions.
  bit                  m_valid [NE];
  logic [SDID_LEN-1:0] m_sdid  [NE];
  logic [TAG_W-1:0]    m_tag   [NE];
  mpt_permissions_e    m_perm  [NE];
  int                  m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_allows(input mpt_permissions_e p, input mpt_access_e a);
    if (a == ACCESS_WRITE) return p inside {ALLOW_RW, ALLOW_RWX};
    if (a == ACCESS_EXEC)  return p inside {ALLOW_RX, ALLOW_RWX};
    return p != DISALLOWED;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    m_rr = 0;
  endtask

  function automatic int m_find(input logic [SDID_LEN-1:0] sd, input logic [TAG_W-1:0] tg);
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_sdid[i] == sd && m_tag[i] == tg) return i;
    return -1;
  endfunction

  task automatic m_fill(input logic [SDID_LEN-1:0] sd, input logic [TAG_W-1:0] tg,
                        input mpt_permissions_e p);
    int slot = -1;
    for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % NE;
    end
    m_valid[slot] = 1'b1;
    m_sdid[slot]  = sd;
    m_tag[slot]   = tg;
    m_perm[slot]  = p;
  endtask

  task automatic m_flush(input logic sv, input logic [SDID_LEN-1:0] sd);
    for (int i = 0; i < NE; i++) if (!sv || m_sdid[i] == sd) m_valid[i] = 1'b0;
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!lookup_ready_o && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("ready_timeout", lookup_ready_o, 1'b1);
  endtask

  task automatic do_flush(input logic sv, input logic [SDID_LEN-1:0] sd);
    flush_i = 1'b1; flush_sdid_valid_i = sv; flush_sdid_i = sd;
    @(posedge clk); #1;
    flush_i = 1'b0;
    m_flush(sv, sd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   lookup_ready_o,  1'b0);
    chk({tag, "_rvalid"},  resp_valid_o,    1'b0);
    chk({tag, "_allow"},   resp_allow_o,    1'b0);
    chk({tag, "_fault"},   resp_fault_o,    1'b0);
    chk({tag, "_perm"},    resp_perm_o,     DISALLOWED);
    chk({tag, "_reqv"},    ptw_req_valid_o, 1'b0);
    chk({tag, "_reqspa"},  ptw_req_spa_o,   '0);
    chk({tag, "_reqsdid"}, ptw_req_sdid_o,  '0);
  endtask

  // One lookup; walks (if needed) with the given walker behaviour and checks the response.
  task automatic lookup(input mpt_mode_e md, input logic [PLEN-1:0] spa,
                        input logic [SDID_LEN-1:0] sd, input mpt_access_e acc,
                        input mpt_permissions_e wperm, input logic werr, input int wlat,
                        input logic wflush, output logic walked, output logic allowed);
    int               idx;
    mpt_permissions_e ep;
    logic             ea, ef;
    wait_ready();
    idx = m_find(sd, spa[PLEN-1:PAGE_OFFSET]);
    mode_i = md; lookup_spa_i = spa; lookup_sdid_i = sd; lookup_access_i = acc;
    lookup_valid_i = 1'b1;
    @(posedge clk); #1;
    lookup_valid_i = 1'b0;
    walked = ptw_req_valid_o;
    if (md == MPT_BARE || idx >= 0) begin
      ep = (md == MPT_BARE) ? ALLOW_RWX : m_perm[idx];
      ea = (md == MPT_BARE) ? 1'b1 : ref_allows(ep, acc);
      ef = 1'b0;
      chk("fast_no_walk", ptw_req_valid_o, 1'b0);
    end else begin
      chk("miss_no_early_resp", resp_valid_o, 1'b0);
      chk("miss_req_valid", ptw_req_valid_o, 1'b1);
      chk("miss_req_spa", ptw_req_spa_o, spa);
      chk("miss_req_sdid", ptw_req_sdid_o, sd);
      for (int i = 0; i < wlat; i++) begin
        @(posedge clk); #1;
        chk("req_held", ptw_req_valid_o, 1'b1);
      end
      ptw_req_ready_i = 1'b1;
      @(posedge clk); #1;
      ptw_req_ready_i = 1'b0;
      chk("req_done", ptw_req_valid_o, 1'b0);
      if (wflush) do_flush(1'b0, '0);
      for (int i = 0; i < wlat; i++) begin
        @(posedge clk); #1;
        chk("wait_no_resp", resp_valid_o, 1'b0);
      end
      ptw_resp_valid_i = 1'b1; ptw_resp_error_i = werr; ptw_resp_perm_i = wperm;
      @(posedge clk); #1;
      ptw_resp_valid_i = 1'b0; ptw_resp_error_i = 1'b0;
      if (werr) begin
        ep = DISALLOWED; ea = 1'b0; ef = 1'b1;
      end else begin
        ep = wperm; ea = ref_allows(wperm, acc); ef = 1'b0;
        if (!wflush) m_fill(sd, spa[PLEN-1:PAGE_OFFSET], wperm);
      end
    end
    chk("resp_valid", resp_valid_o, 1'b1);
    chk("resp_allow", resp_allow_o, ea);
    chk("resp_fault", resp_fault_o, ef);
    chk("resp_perm",  resp_perm_o,  ep);
    allowed = resp_allow_o;
  endtask

  initial begin : stim
    logic             w, a;
    logic [PLEN-1:0]  spa;
    mpt_permissions_e perms [5];
    perms = '{DISALLOWED, ALLOW_R, ALLOW_RW, ALLOW_RX, ALLOW_RWX};

    rst_i = 1'b1; mode_i = MPT_SMMPT43; lookup_valid_i = 1'b0; lookup_spa_i = '0;
    lookup_sdid_i = '0; lookup_access_i = ACCESS_NONE; ptw_req_ready_i = 1'b0;
    ptw_resp_valid_i = 1'b0; ptw_resp_error_i = 1'b0; ptw_resp_perm_i = DISALLOWED;
    flush_i = 1'b0; flush_sdid_valid_i = 1'b0; flush_sdid_i = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_i = 1'b0;

    // Cold miss, then hit without a walk.
    lookup(MPT_SMMPT43, 56'h1234_5000, 6'd3, ACCESS_READ, ALLOW_RX, 1'b0, 0, 1'b0, w, a);
    chk("cold_walked", w, 1'b1);
    chk("cold_allow", a, 1'b1);
    lookup(MPT_SMMPT43, 56'h1234_5abc, 6'd3, ACCESS_READ, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
    chk("rehit_no_walk", w, 1'b0);

    // Permission check against the ALLOW_RX entry.
    lookup(MPT_SMMPT43, 56'h1234_5000, 6'd3, ACCESS_WRITE, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
    chk("rx_write_denied", a, 1'b0);
    lookup(MPT_SMMPT43, 56'h1234_5000, 6'd3, ACCESS_EXEC, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
    chk("rx_exec_allowed", a, 1'b1);

    // Back-to-back hits, one response per cycle.
    lookup_valid_i = 1'b1; mode_i = MPT_SMMPT43; lookup_spa_i = 56'h1234_5000;
    lookup_sdid_i = 6'd3; lookup_access_i = ACCESS_READ;
    @(posedge clk); #1;
    chk("b2b_first_valid", resp_valid_o, 1'b1);
    chk("b2b_first_allow", resp_allow_o, 1'b1);
    lookup_access_i = ACCESS_WRITE;
    @(posedge clk); #1;
    lookup_valid_i = 1'b0;
    chk("b2b_second_valid", resp_valid_o, 1'b1);
    chk("b2b_second_allow", resp_allow_o, 1'b0);
    @(posedge clk); #1;
    chk("resp_single_pulse", resp_valid_o, 1'b0);

    // Walk error: fault, no fill, so the same page walks again.
    lookup(MPT_SMMPT43, 56'h2222_3000, 6'd3, ACCESS_READ, ALLOW_RWX, 1'b1, 1, 1'b0, w, a);
    chk("err_walked", w, 1'b1);
    chk("err_fault", resp_fault_o, 1'b1);
    lookup(MPT_SMMPT43, 56'h2222_3000, 6'd3, ACCESS_READ, ALLOW_RWX, 1'b0, 2, 1'b0, w, a);
    chk("err_rewalk", w, 1'b1);

    // Selective flush.
    lookup(MPT_SMMPT43, 56'h5555_0000, 6'd5, ACCESS_READ, ALLOW_R, 1'b0, 0, 1'b0, w, a);
    do_flush(1'b1, 6'd3);
    lookup(MPT_SMMPT43, 56'h1234_5000, 6'd3, ACCESS_READ, ALLOW_RX, 1'b0, 0, 1'b0, w, a);
    chk("sel_flush_sdid3_miss", w, 1'b1);
    lookup(MPT_SMMPT43, 56'h5555_0000, 6'd5, ACCESS_READ, ALLOW_R, 1'b0, 0, 1'b0, w, a);
    chk("sel_flush_sdid5_hit", w, 1'b0);

    // Flush in WALK_WAIT: response delivered, fill dropped.
    lookup(MPT_SMMPT43, 56'h6666_0000, 6'd4, ACCESS_READ, ALLOW_RW, 1'b0, 1, 1'b1, w, a);
    chk("wait_flush_allow", a, 1'b1);
    lookup(MPT_SMMPT43, 56'h6666_0000, 6'd4, ACCESS_READ, ALLOW_RW, 1'b0, 0, 1'b0, w, a);
    chk("wait_flush_refetch", w, 1'b1);

    // Flush and hit in the same cycle: answered from pre-flush contents.
    wait_ready();
    lookup_valid_i = 1'b1; lookup_spa_i = 56'h6666_0000; lookup_sdid_i = 6'd4;
    lookup_access_i = ACCESS_WRITE; flush_i = 1'b1; flush_sdid_valid_i = 1'b0;
    @(posedge clk); #1;
    lookup_valid_i = 1'b0; flush_i = 1'b0;
    m_flush(1'b0, '0);
    chk("flush_hit_valid", resp_valid_o, 1'b1);
    chk("flush_hit_perm", resp_perm_o, ALLOW_RW);
    chk("flush_hit_allow", resp_allow_o, 1'b1);
    lookup(MPT_SMMPT43, 56'h6666_0000, 6'd4, ACCESS_READ, ALLOW_RW, 1'b0, 0, 1'b0, w, a);
    chk("flush_hit_then_miss", w, 1'b1);

    // Replacement: 9 distinct pages into 8 entries evicts entry 0.
    rst_i = 1'b1; @(posedge clk); #1; rst_i = 1'b0; m_reset();
    for (int i = 0; i < 9; i++) begin
      spa = 56'h1000_0000 + PLEN'(i) * 56'h1000;
      lookup(MPT_SMMPT52, spa, 6'd1, ACCESS_READ, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
      chk("repl_fill_walk", w, 1'b1);
    end
    lookup(MPT_SMMPT52, 56'h1000_0000, 6'd1, ACCESS_READ, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
    chk("repl_first_evicted", w, 1'b1);
    lookup(MPT_SMMPT52, 56'h1000_8000, 6'd1, ACCESS_READ, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
    chk("repl_ninth_hits", w, 1'b0);

    // Reset during WALK_WAIT, late walker response ignored.
    wait_ready();
    lookup_valid_i = 1'b1; mode_i = MPT_SMMPT43; lookup_spa_i = 56'h7777_7000;
    lookup_sdid_i = 6'd2; lookup_access_i = ACCESS_READ;
    @(posedge clk); #1;
    lookup_valid_i = 1'b0;
    chk("rst_walk_req", ptw_req_valid_o, 1'b1);
    ptw_req_ready_i = 1'b1;
    @(posedge clk); #1;
    ptw_req_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk_all_zero("midwalk_rst");
    @(posedge clk); #1;
    rst_i = 1'b0; m_reset();
    ptw_resp_valid_i = 1'b1; ptw_resp_perm_i = ALLOW_RWX;
    @(posedge clk); #1;
    ptw_resp_valid_i = 1'b0;
    chk("late_resp_ignored", resp_valid_o, 1'b0);
    lookup(MPT_SMMPT52, 56'h1000_8000, 6'd1, ACCESS_READ, ALLOW_RWX, 1'b0, 0, 1'b0, w, a);
    chk("rst_entries_invalid", w, 1'b1);

    // BARE mode: immediate allow, never a walk.
    lookup(MPT_BARE, 56'h0abc_d000, 6'd7, ACCESS_WRITE, DISALLOWED, 1'b0, 0, 1'b0, w, a);
    chk("bare_no_walk", w, 1'b0);
    chk("bare_allow", a, 1'b1);
    @(posedge clk); #1;
    chk("bare_no_walk_later", ptw_req_valid_o, 1'b0);

    // Randomized traffic over a small page pool to exercise hits, evictions and flushes.
    for (int n = 0; n < 200; n++) begin
      logic [SDID_LEN-1:0] sd;
      mpt_mode_e           md;
      sd  = ($urandom_range(0, 1) == 0) ? 6'd3 : 6'd5;
      spa = 56'h4000_0000 + PLEN'($urandom_range(0, 11)) * 56'h1000
            + PLEN'($urandom_range(0, 4095));
      md  = ($urandom_range(0, 15) == 0) ? MPT_BARE : MPT_SMMPT43;
      lookup(md, spa, sd, mpt_access_e'($urandom_range(0, 3)),
             perms[$urandom_range(0, 4)], ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 2)), ($urandom_range(0, 19) == 0), w, a);
      if ($urandom_range(0, 19) == 0)
        do_flush(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 0) ? 6'd3 : 6'd5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
